// File: rtl/test_sequencer_pkg.sv
// test_sequencer_pkg
//   Shared types and sizing helpers for the test sequencer.
//   - seq_state_t     : sequencer FSM states
//   - cnt_width()     : watchdog counter width able to hold max(ack_wait, timeout)
//   - fail_cnt_width(): width of a count that can reach n
//   - CNT_W           : counter width for the default ACK_WAIT / TIMEOUT values
package test_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE
    } seq_state_t;

    localparam int DEF_ACK_WAIT = 16;
    localparam int DEF_TIMEOUT  = 100000;

    function automatic int cnt_width(input int ack_wait, input int timeout);
        int m;
        m = (ack_wait > timeout) ? ack_wait : timeout;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic int fail_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEF_ACK_WAIT, DEF_TIMEOUT);

endpackage

// File: rtl/test_sequencer_watchdog.sv
// seq_watchdog
//   Loadable, saturating down-counter used to bound how long the sequencer
//   waits in a state.  Loading sets the budget; each enabled cycle consumes
//   one unit; the count stops at zero and never wraps.
//   `expired` is high during the enabled cycle that uses the last unit of
//   budget, so a limit of L allows exactly L enabled cycles, the first one
//   included.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   clr          force the count to zero (highest priority)
//   load         load `limit` as the remaining budget
//   en           consume one cycle of budget
//   limit        budget value loaded by `load`
//   expired      last allowed cycle is the current one (only while en)
module seq_watchdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (!reset) begin
            remaining <= '0;
        end else if (clr) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= limit;
        end else if (en && (remaining != '0)) begin
            remaining <= remaining - W'(1);
        end
    end

    // A zero budget counts as already spent.
    assign expired = en && (remaining <= W'(1));

endmodule

// File: rtl/test_sequencer.sv
// test_sequencer
//   Runs a bank of req/busy/return method units one after another on a
//   single `start`, recording a pass bit per unit and a failure count.
//   A unit fails if it returns 0, never acknowledges with busy within
//   ACK_WAIT cycles, or (with SEQ_TIMEOUT_EN defined) stays busy for
//   TIMEOUT cycles.
// Configuration macro:
//   SEQ_TIMEOUT_EN  enables the WAIT_DONE watchdog; without it WAIT_DONE
//                   waits indefinitely and TIMEOUT only affects sizing.
// Ports:
//   clk, reset    clock, synchronous active-low reset
//   start         one-cycle run request (honoured in IDLE and DONE only)
//   test_req      per-unit request, at most one bit high
//   test_busy     per-unit busy
//   test_return   per-unit result, sampled on the first non-busy cycle
//   busy          sequence in progress
//   done          sequence finished, results held
//   pass_mask     bit i = unit i passed
//   fail_count    number of failed units
//   all_pass      done with no failures
module test_sequencer
    import test_sequencer_pkg::*;
#(
    parameter int N_TESTS  = 4,
    parameter int ACK_WAIT = 16,
    parameter int TIMEOUT  = 100000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic [N_TESTS-1:0]                  test_req,
    input  logic [N_TESTS-1:0]                  test_busy,
    input  logic [N_TESTS-1:0]                  test_return,
    output logic                                busy,
    output logic                                done,
    output logic [N_TESTS-1:0]                  pass_mask,
    output logic [fail_cnt_width(N_TESTS)-1:0]  fail_count,
    output logic                                all_pass
);

    localparam int CW = cnt_width(ACK_WAIT, TIMEOUT);
    localparam int FW = fail_cnt_width(N_TESTS);
    localparam int IW = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_TESTS - 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(N_TESTS);

    seq_state_t           state, state_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [N_TESTS-1:0]   pass_q, pass_nx;
    logic [FW-1:0]        fcnt_q, fcnt_nx, fcnt_inc;
    logic [N_TESTS-1:0]   sel;
    logic                 cur_busy, cur_ret;
    logic                 ack_exp, to_exp;
    logic                 idle_like;

    assign sel       = N_TESTS'(1) << idx;
    assign cur_busy  = test_busy[idx];
    assign cur_ret   = test_return[idx];
    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign fcnt_inc  = (fcnt_q == FAIL_MAX) ? fcnt_q : fcnt_q + FW'(1);

    // Ack budget: loaded while waiting for the unit to go idle, spent in LAUNCH.
    seq_watchdog #(.W(CW)) u_ack_wd (
        .clk     (clk),
        .reset   (reset),
        .clr     (idle_like),
        .load    (state == S_WAIT_IDLE),
        .en      (state == S_LAUNCH),
        .limit   (CW'(ACK_WAIT)),
        .expired (ack_exp)
    );

`ifdef SEQ_TIMEOUT_EN
    // Completion budget: loaded during LAUNCH, spent in WAIT_DONE.
    seq_watchdog #(.W(CW)) u_to_wd (
        .clk     (clk),
        .reset   (reset),
        .clr     (idle_like),
        .load    (state == S_LAUNCH),
        .en      (state == S_WAIT_DONE),
        .limit   (CW'(TIMEOUT)),
        .expired (to_exp)
    );
`else
    assign to_exp = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            pass_q <= '0;
            fcnt_q <= '0;
        end else begin
            state  <= state_nx;
            idx    <= idx_nx;
            pass_q <= pass_nx;
            fcnt_q <= fcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        pass_nx  = pass_q;
        fcnt_nx  = fcnt_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pass_nx  = '0;
                    fcnt_nx  = '0;
                    idx_nx   = '0;
                    state_nx = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (!cur_busy) state_nx = S_LAUNCH;
            end
            S_LAUNCH: begin
                // An ack on the last budget cycle still counts as an ack.
                if (cur_busy) begin
                    state_nx = S_WAIT_DONE;
                end else if (ack_exp) begin
                    fcnt_nx  = fcnt_inc;
                    state_nx = S_NEXT;
                end
            end
            S_WAIT_DONE: begin
                if (!cur_busy) begin
                    if (cur_ret) pass_nx = pass_q | sel;
                    else         fcnt_nx = fcnt_inc;
                    state_nx = S_NEXT;
                end else if (to_exp) begin
                    fcnt_nx  = fcnt_inc;
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx == LAST_IDX) begin
                    state_nx = S_DONE;
                end else begin
                    idx_nx   = idx + IW'(1);
                    state_nx = S_WAIT_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Request is a pure decode of LAUNCH, so it drops the cycle after busy
    // is seen and can never be high for two units at once.
    assign test_req   = (state == S_LAUNCH) ? sel : '0;
    assign busy       = !idle_like;
    assign done       = (state == S_DONE);
    assign pass_mask  = pass_q;
    assign fail_count = fcnt_q;
    assign all_pass   = done && (fcnt_q == '0);

endmodule
